// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default bit timing.
// Used by the transmitter and, later, by the receiver and its bit timer.
package uart_pkg;

    localparam int UART_BIT_CLK_DEFAULT = 87;
    localparam int UART_DATA_BITS       = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..BIT_CLK-1 and wraps, flags the last cycle of a bit.
// Latency: bit_done is combinational from the count register; clear takes effect next cycle.
// Backpressure: none, free-running whenever clear is low.
module uart_bit_timer #(
    parameter int BIT_CLK = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CLK - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined), LSB first, BIT_CLK cycles per bit.
// Latency: txd drops for the start bit right after the handshake edge; frame is 10 (11) bit periods.
// Backpressure: tx_ready only in IDLE, so continuous tx_valid yields one idle cycle between frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_CLK = UART_BIT_CLK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] txdata,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam logic [2:0] LAST_INDEX = 3'(UART_DATA_BITS - 1);

    uart_state_t state;
    logic [7:0]  shreg;
    logic [2:0]  index;
    logic [2:0]  index_nxt;
    logic        bit_done;

    // Holding the timer cleared while idle makes every frame start at count 0.
    uart_bit_timer #(
        .BIT_CLK (BIT_CLK)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == IDLE),
        .bit_done (bit_done)
    );

    assign index_nxt = index + 3'd1;
    assign tx_ready  = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // txd is loaded with the level of the state being entered, so it lines up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            txd   <= 1'b1;
            shreg <= '0;
            index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (tx_valid) begin
                        shreg <= txdata;
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        index <= '0;
                        state <= DATA;
                        txd   <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (index == LAST_INDEX) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            txd   <= ^shreg;
`else
                            state <= STOP;
                            txd   <= 1'b1;
`endif
                        end else begin
                            index <= index_nxt;
                            txd   <= shreg[index_nxt];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    txd <= 1'b1;
                    if (bit_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter: accepts one 8-bit word over a valid/ready handshake and serialises it onto `txd` as 8N1, LSB first, with every bit held for `BIT_CLK` clock cycles. It pairs with the existing UART receiver: same `BIT_CLK` convention, same line idle level, and no oversampling. It sits between the system-side byte source, such as a FIFO or command logic, and the external TX pin.

## Interface
- `BIT_CLK`, default 87: clock cycles per serial bit. Minimum legal value is 2.
- `clk` input 1: the single system clock.
- `rst` input 1: synchronous, active-high reset.
- `txdata` input 8: byte to transmit; sampled only on handshake.
- `tx_valid` input 1: source has a byte on `txdata`.
- `tx_ready` output 1: transmitter can accept a byte this cycle.
- `txd` output 1: serial line; idles high.
- `busy` output 1: a frame is in progress (any state other than IDLE).

## Operation
- **States:** IDLE, START, DATA, PARITY (present only when the parity macro is defined), STOP.
- **Counters:**
  - `count` is `$clog2(BIT_CLK)` bits wide and spans 0..BIT_CLK-1.
  - `index` is 3 bits and selects the data bit 0..7.
- **IDLE:**
  - Outputs: `txd`=1, `tx_ready`=1, `busy`=0.
  - On `tx_valid && tx_ready`, latch `txdata` into a shift register, clear `count`, and go to START.
- **START:** `txd`=0. When `count == BIT_CLK-1`, clear `count`, set `index`=0, and go to DATA.
- **DATA:**
  - `txd` = shift register bit `index`.
  - When `count == BIT_CLK-1`, clear `count`. If `index == 7`, go to PARITY when enabled, otherwise STOP; else increment `index`.
- **PARITY:** `txd` = XOR of the latched byte (even parity). After BIT_CLK cycles, go to STOP.
- **STOP:** `txd`=1. When `count == BIT_CLK-1`, go to IDLE.
- `tx_ready` is combinational and equals `state == IDLE && !rst`.
- `txdata` is ignored outside the handshake cycle. A change on `txdata` mid-frame does not affect the frame.
- `tx_valid` held high continuously sends back-to-back frames, each separated by exactly one IDLE cycle.
- Illegal or unreachable state encodings go to IDLE with `txd`=1.

## Timing
- **Reset values:** `txd`=1, `busy`=0, state=IDLE, `count`=0, `index`=0. `tx_ready` reads 0 while `rst` is high and 1 in the first cycle after release.
- **Reset mid-frame:** the frame is aborted. `txd` is high from the cycle after the `rst` edge, and no partial byte is resumed.
- `txd` is registered.
- **Latency:** with the handshake at rising edge N, `txd` falls from edge N+1.
- Each bit lasts exactly BIT_CLK cycles. There is no jitter and no fractional bit.
- **Frame length:** 10·BIT_CLK cycles (11·BIT_CLK with parity).
- **Frame period under continuous valid:** 10·BIT_CLK+1 cycles (11·BIT_CLK+1 with parity).
- **Simultaneous valid and reset:** reset wins and the byte is not accepted.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- **Defined:** an even-parity bit is inserted between D7 and STOP, and the frame is 8E1.
- **Undefined:** the PARITY state and the XOR logic are absent, and the frame is 8N1, matching the current receiver.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding constants: IDLE=0, START=1, DATA=2, STOP=3, PARITY=4.
  - `UART_BIT_CLK_DEFAULT`=87.
  - `UART_DATA_BITS`=8.
- **Sub-module `uart_bit_timer`:**
  - Parameter `BIT_CLK`.
  - Ports `clk`, `rst`, `clear` in, `bit_done` out.
  - `bit_done` asserts when `count == BIT_CLK-1`.
  - It is reusable by the receiver later.

## Test plan
- **Reset idle:** hold `rst` for 3 cycles, then release → `txd`=1, `busy`=0, and `tx_ready`=1 on the first post-reset cycle.
- **Single byte:** BIT_CLK=4, send 0xA5 → `txd` is low for cycles 1–4 after the handshake, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles; `tx_ready` returns to 1 at cycle 41.
- **Back-to-back:** BIT_CLK=4, `tx_valid` held high with 0x00 then 0xFF → the second start bit begins exactly 41 cycles after the first, with a single idle-high cycle between frames.
- **Data stability:** change `txdata` every cycle mid-frame while sending 0x3C → the decoded line carries 0x3C.
- **Reset mid-frame:** assert `rst` during bit D3 → `txd`=1 next cycle, `busy`=0, and no further edges appear.
- **Parity:** with `UART_TX_PARITY_EN`, send 0x07 → the parity bit is 1 and the frame is 44 cycles at BIT_CLK=4; with 0x03 the parity bit is 0.
